// File: rtl/mmu_sequencer_if.sv
// Command/status/strobe bundle between a host controller and the MMU sequencer.
interface mmu_sequencer_if #(
   parameter int ADDR_BITS = 8
);
   logic                 start;
   logic                 abort;
   logic                 skip_wload;
   logic                 accumulate;
   logic [ADDR_BITS-1:0] ub_base;
   logic [ADDR_BITS-1:0] wb_base;
   logic [ADDR_BITS-1:0] acc_base;
   logic [ADDR_BITS-1:0] rows;

   logic                 busy;
   logic                 done;
   logic                 read_wb;
   logic                 weight_fifo_en;
   logic                 mmu_load_weight_en;
   logic                 read_ub;
   logic                 data_fifo_en;
   logic                 mm_en;
   logic                 write_acc;
   logic                 acc_en;
   logic [ADDR_BITS-1:0] addrb;
   logic [ADDR_BITS-1:0] addra;

   modport slave (
      input  start, abort, skip_wload, accumulate, ub_base, wb_base, acc_base, rows,
      output busy, done, read_wb, weight_fifo_en, mmu_load_weight_en, read_ub,
             data_fifo_en, mm_en, write_acc, acc_en, addrb, addra
   );

   modport master (
      output start, abort, skip_wload, accumulate, ub_base, wb_base, acc_base, rows,
      input  busy, done, read_wb, weight_fifo_en, mmu_load_weight_en, read_ub,
             data_fifo_en, mm_en, write_acc, acc_en, addrb, addra
   );
endinterface

// File: rtl/mmu_sequencer.sv
// Sequences weight load, activation streaming and accumulator write-back for a systolic MMU.
// state  | meaning
// IDLE   | waiting for start; strobes low
// WLOAD  | fetch ARRAY_DIM weight rows through the weight FIFO into the array
// STREAM | stream activation rows, run the array, write results to the accumulator
// DONE   | one-cycle completion pulse
module mmu_sequencer #(
   parameter int ADDR_BITS  = 8,
   parameter int ARRAY_DIM  = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int MMU_LAT    = 31
) (
   input logic            clk,
   input logic            reset_n,
   mmu_sequencer_if.slave bus
);

   localparam int CNT_W = $clog2((1 << ADDR_BITS) + ARRAY_DIM + FIFO_DEPTH + MMU_LAT + 2);
   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [ADDR_BITS-1:0] addr_t;

   localparam cnt_t ONE      = cnt_t'(1);
   localparam cnt_t WB_END   = cnt_t'(ARRAY_DIM);
   localparam cnt_t WL_LAST  = cnt_t'(ARRAY_DIM + FIFO_DEPTH);
   localparam cnt_t FD       = cnt_t'(FIFO_DEPTH);
   localparam cnt_t MM_START = cnt_t'(FIFO_DEPTH + 1);
   localparam cnt_t WR_OFF   = cnt_t'(FIFO_DEPTH + MMU_LAT + 1);

   typedef enum logic [1:0] {IDLE, WLOAD, STREAM, DONE} state_t;

   state_t state_q, state_d;
   cnt_t   cnt_q, cnt_d;

   addr_t rows_q, ub_q, wb_q, accb_q;
   logic  accum_q;

   logic  busy_q, busy_d, done_q, done_d;
   logic  read_wb_q, read_wb_d, wfe_q, wfe_d, mlw_q, mlw_d;
   logic  read_ub_q, read_ub_d, dfe_q, dfe_d, mm_en_q, mm_en_d;
   logic  write_acc_q, write_acc_d, acc_en_q, acc_en_d;
   addr_t addrb_q, addrb_d, addra_q, addra_d;

   logic  accept;
   addr_t rows_c, ub_c, wb_c, accb_c;
   logic  accum_c;
   cnt_t  rows_w, str_last;

   // Abort outranks start, so a start coinciding with abort is dropped.
   assign accept   = (state_q == IDLE) && bus.start && !bus.abort;
   assign rows_c   = accept ? bus.rows       : rows_q;
   assign ub_c     = accept ? bus.ub_base    : ub_q;
   assign wb_c     = accept ? bus.wb_base    : wb_q;
   assign accb_c   = accept ? bus.acc_base   : accb_q;
   assign accum_c  = accept ? bus.accumulate : accum_q;
   assign rows_w   = cnt_t'(rows_c);
   assign str_last = rows_w + WR_OFF - ONE;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + ONE;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      read_wb_d   = 1'b0;
      wfe_d       = 1'b0;
      mlw_d       = 1'b0;
      read_ub_d   = 1'b0;
      dfe_d       = 1'b0;
      mm_en_d     = 1'b0;
      write_acc_d = 1'b0;
      acc_en_d    = 1'b0;
      addrb_d     = addrb_q;
      addra_d     = addra_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               if (bus.rows == '0)   state_d = DONE;
               else if (bus.skip_wload) state_d = STREAM;
               else                  state_d = WLOAD;
            end
         end
         WLOAD: begin
            if (bus.abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == WL_LAST) begin
               state_d = STREAM;
               cnt_d   = '0;
            end
         end
         STREAM: begin
            if (bus.abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == str_last) begin
               state_d = DONE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are decoded from the upcoming state/count so the registers line up with it.
      case (state_d)
         WLOAD: begin
            busy_d = 1'b1;
            if (cnt_d < WB_END) begin
               read_wb_d = 1'b1;
               addrb_d   = wb_c + cnt_d[ADDR_BITS-1:0];
            end
            wfe_d = (cnt_d >= ONE) && (cnt_d <= WL_LAST);
            mlw_d = (cnt_d >= MM_START);
         end
         STREAM: begin
            busy_d = 1'b1;
            if (cnt_d < rows_w) begin
               read_ub_d = 1'b1;
               addrb_d   = ub_c + cnt_d[ADDR_BITS-1:0];
            end
            dfe_d   = (cnt_d >= ONE) && (cnt_d <= rows_w + FD);
            mm_en_d = (cnt_d >= MM_START);
            if (cnt_d >= WR_OFF) begin
               write_acc_d = 1'b1;
               acc_en_d    = accum_c;
               addra_d     = accb_c + cnt_d[ADDR_BITS-1:0] - WR_OFF[ADDR_BITS-1:0];
            end
         end
         DONE:    done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rows_q      <= '0;
         ub_q        <= '0;
         wb_q        <= '0;
         accb_q      <= '0;
         accum_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         read_wb_q   <= 1'b0;
         wfe_q       <= 1'b0;
         mlw_q       <= 1'b0;
         read_ub_q   <= 1'b0;
         dfe_q       <= 1'b0;
         mm_en_q     <= 1'b0;
         write_acc_q <= 1'b0;
         acc_en_q    <= 1'b0;
         addrb_q     <= '0;
         addra_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         if (accept) begin
            rows_q  <= bus.rows;
            ub_q    <= bus.ub_base;
            wb_q    <= bus.wb_base;
            accb_q  <= bus.acc_base;
            accum_q <= bus.accumulate;
         end
         busy_q      <= busy_d;
         done_q      <= done_d;
         read_wb_q   <= read_wb_d;
         wfe_q       <= wfe_d;
         mlw_q       <= mlw_d;
         read_ub_q   <= read_ub_d;
         dfe_q       <= dfe_d;
         mm_en_q     <= mm_en_d;
         write_acc_q <= write_acc_d;
         acc_en_q    <= acc_en_d;
         addrb_q     <= addrb_d;
         addra_q     <= addra_d;
      end
   end

   assign bus.busy               = busy_q;
   assign bus.done               = done_q;
   assign bus.read_wb            = read_wb_q;
   assign bus.weight_fifo_en     = wfe_q;
   assign bus.mmu_load_weight_en = mlw_q;
   assign bus.read_ub            = read_ub_q;
   assign bus.data_fifo_en       = dfe_q;
   assign bus.mm_en              = mm_en_q;
   assign bus.write_acc          = write_acc_q;
   assign bus.acc_en             = acc_en_q;
   assign bus.addrb              = addrb_q;
   assign bus.addra              = addra_q;

endmodule

// File: doc/mmu_sequencer.md
MMU_SEQUENCER -- requirements
Module: mmu_sequencer

Interface
REQ-001 SHALL have parameters: ADDR_BITS 8, BRAM address width; ARRAY_DIM 16, systolic rows/cols; FIFO_DEPTH 4, data/weight FIFO stages; MMU_LAT 31, MMU input-to-output cycles.
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; reset_n input 1, async active-low reset.
REQ-003 SHALL have the control inputs:
- start input 1, single-cycle command strobe
- abort input 1, synchronous cancel
- skip_wload input 1, reuse resident weights
- accumulate input 1, add into the accumulator instead of overwriting
REQ-004 SHALL have the address/length inputs: ub_base, wb_base and acc_base, each input ADDR_BITS, base addresses; rows input ADDR_BITS, activation row count.
REQ-005 SHALL have the status outputs: busy output 1, command in progress; done output 1, one-cycle completion pulse.
REQ-006 SHALL have the datapath strobes, each output 1: read_wb, weight_fifo_en, mmu_load_weight_en, read_ub, data_fifo_en, mm_en, write_acc, acc_en.
REQ-007 SHALL have the address outputs: addrb output ADDR_BITS, BRAM read address; addra output ADDR_BITS, accumulator write address.

Function
REQ-008 SHALL implement states IDLE, WLOAD, STREAM, DONE, with a cycle counter cnt cleared on every state entry.
REQ-009 SHALL register all outputs, which change only on rising clk edges.
REQ-010 SHALL accept start only in IDLE, latching every command input; start while busy=1 SHALL be ignored, with no queueing.
REQ-011 SHALL, on accepted start, take IDLE->DONE if rows==0, else IDLE->STREAM if skip_wload=1, else IDLE->WLOAD.
REQ-012 SHALL last ARRAY_DIM+FIFO_DEPTH+1 cycles in WLOAD (cnt 0..ARRAY_DIM+FIFO_DEPTH), then go to STREAM.
REQ-013 SHALL drive WLOAD: read_wb=1 with addrb=wb_base+cnt for cnt<ARRAY_DIM; weight_fifo_en=1 for 1<=cnt<=ARRAY_DIM+FIFO_DEPTH; mmu_load_weight_en=1 for cnt>=FIFO_DEPTH+1.
REQ-014 SHALL last L=rows+FIFO_DEPTH+MMU_LAT+1 cycles in STREAM (cnt 0..L-1), then go to DONE.
REQ-015 SHALL drive STREAM reads and compute: read_ub=1 with addrb=ub_base+cnt for cnt<rows; data_fifo_en=1 for 1<=cnt<=rows+FIFO_DEPTH; mm_en=1 for FIFO_DEPTH+1<=cnt<=L-1.
REQ-016 SHALL drive STREAM writes: write_acc=1 for FIFO_DEPTH+MMU_LAT+1<=cnt<=L-1, with addra=acc_base+(cnt-FIFO_DEPTH-MMU_LAT-1); acc_en=latched accumulate while write_acc=1, else 0.
REQ-017 SHALL compute all address sums modulo 2^ADDR_BITS, wrapping 255->0 silently.
REQ-018 SHALL hold addra/addrb at last value when their strobes are 0.
REQ-019 SHALL stay in DONE for exactly one cycle with done=1, busy=0 and all strobes 0, then return to IDLE.
REQ-020 SHALL hold busy=1 exactly while in WLOAD or STREAM.
REQ-021 SHALL, on abort=1 in WLOAD or STREAM, enter IDLE on the next edge with all strobes 0 and no done pulse; abort in IDLE/DONE SHALL have no effect.
REQ-022 SHALL give abort priority over start when both are asserted in the same cycle, so the start is dropped.
REQ-023 SHALL accept a start presented in the cycle right after DONE.

Reset
REQ-024 SHALL, while reset_n=0, force state IDLE, cnt=0, and all outputs (busy, done, strobes, addra, addrb) to 0, asynchronously.
REQ-025 SHALL, on reset mid-command, discard the command with no done pulse.
REQ-026 SHALL, after reset_n rises, accept start on the first clock edge.

Verification
REQ-027 SHALL cover the full command: start with rows=8, ub_base=0x10, wb_base=0x40, acc_base=0x80 -> busy=1 for 21+44=65 cycles; read_wb addrb 0x40..0x4F; read_ub addrb 0x10..0x17; write_acc addra 0x80..0x87; done one cycle later.
REQ-028 SHALL cover skip_wload=1 with rows=1 -> no read_wb/mmu_load_weight_en pulses; busy=1 for 37 cycles; one write_acc at acc_base.
REQ-029 SHALL cover wrap: rows=4, ub_base=0xFE, acc_base=0xFF, accumulate=1 -> addrb 0xFE,0xFF,0x00,0x01; addra 0xFF,0x00,0x01,0x02 with acc_en=1.
REQ-030 SHALL cover rows=0 -> done on the cycle after start; busy and all strobes stay 0.
REQ-031 SHALL cover abort at STREAM cnt=10 together with a start -> IDLE next cycle; strobes 0; no done; the following start runs normally.
REQ-032 SHALL cover reset_n pulsed low in WLOAD -> all outputs 0 immediately, before any clk edge; no done after release.
